// File: rtl/vga_pkg.sv
// Shared definitions for the pixel-clock domain: button indices, repeat FSM
// encoding and default timing derived from the 148.5 MHz pixel clock.
package vga_pkg;

    localparam int PIX_CLK_HZ = 148_500_000;

    localparam int DEBOUNCE_CYCLES_DEF = PIX_CLK_HZ / 100;  // 10 ms
    localparam int REPEAT_DELAY_DEF    = PIX_CLK_HZ / 2;    // 500 ms
    localparam int REPEAT_PERIOD_DEF   = PIX_CLK_HZ / 10;   // 100 ms

    localparam int BTN_R = 0;
    localparam int BTN_L = 1;
    localparam int BTN_U = 2;
    localparam int BTN_D = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } rpt_state_t;

endpackage

// File: rtl/btn_debounce_repeat.sv
// One button: 2-flop synchroniser, stability-count debouncer, press/auto-repeat FSM.
// Latency: raw edge to level/pulse is 2 + DEBOUNCE_CYCLES cycles (unregistered pulse).
// Backpressure: none; pulse is a single-cycle strobe that cannot be stalled.
module btn_debounce_repeat
    import vga_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic pulse
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RW = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;
    localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_MAX  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_MAX = RW'(REPEAT_PERIOD - 1);

    logic          sync_a, sync_b;
    logic          db;
    logic [CW-1:0] cnt;

    rpt_state_t    state, state_nxt;
    logic [RW-1:0] rcnt, rcnt_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            db     <= 1'b0;
            cnt    <= '0;
        end else begin
            sync_a <= btn;
            sync_b <= sync_a;
            if (sync_b == db) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                db  <= sync_b;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            rcnt  <= '0;
        end else begin
            state <= state_nxt;
            rcnt  <= rcnt_nxt;
        end
    end

    // IDLE is only ever entered with db low, so db high in IDLE marks a fresh press.
    always_comb begin
        state_nxt = state;
        rcnt_nxt  = rcnt;
        case (state)
            IDLE: begin
                if (db) begin
                    state_nxt = HOLD;
                    rcnt_nxt  = '0;
                end
            end
            HOLD: begin
                if (!db) begin
                    state_nxt = IDLE;
                end else if (rcnt == DELAY_MAX) begin
                    if (REPEAT_EN) begin
                        state_nxt = REPEAT;
                        rcnt_nxt  = '0;
                    end
                end else begin
                    rcnt_nxt = rcnt + 1'b1;
                end
            end
            REPEAT: begin
                if (!db) begin
                    state_nxt = IDLE;
                end else if (rcnt == PERIOD_MAX) begin
                    rcnt_nxt = '0;
                end else begin
                    rcnt_nxt = rcnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                rcnt_nxt  = '0;
            end
        endcase
    end

    always_comb begin
        pulse = 1'b0;
        case (state)
            IDLE:    pulse = db;
            HOLD:    pulse = db && REPEAT_EN && (rcnt == DELAY_MAX);
            REPEAT:  pulse = db && (rcnt == PERIOD_MAX);
            default: pulse = 1'b0;
        endcase
    end

    assign level = db;

endmodule

// File: rtl/btn_step_conditioner.sv
// Four-button step-pulse conditioner with opposing-pair suppression, registered outputs.
// Latency: raw press to pulse/level is DEBOUNCE_CYCLES + 3 cycles.
// Backpressure: none; consumers must take each one-cycle strobe when it appears.
module btn_step_conditioner
    import vga_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btnR,
    input  logic       btnL,
    input  logic       btnU,
    input  logic       btnD,
    output logic       pulseR,
    output logic       pulseL,
    output logic       pulseU,
    output logic       pulseD,
    output logic [3:0] btn_level
);

    logic [3:0] raw_btn;
    logic [3:0] db;
    logic [3:0] raw_pulse;
    logic [3:0] arb_pulse;
    logic [3:0] pulse_q;
    logic [3:0] level_q;

    assign raw_btn = {btnD, btnU, btnL, btnR};

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_debounce_repeat #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .REPEAT_EN       (REPEAT_EN)
        ) u_btn (
            .clk   (clk),
            .reset (reset),
            .btn   (raw_btn[i]),
            .level (db[i]),
            .pulse (raw_pulse[i])
        );
    end

    // Coincident opposing steps cancel outright rather than being deferred.
    always_comb begin
        arb_pulse = raw_pulse;
        if (raw_pulse[BTN_R] && raw_pulse[BTN_L]) begin
            arb_pulse[BTN_R] = 1'b0;
            arb_pulse[BTN_L] = 1'b0;
        end
        if (raw_pulse[BTN_U] && raw_pulse[BTN_D]) begin
            arb_pulse[BTN_U] = 1'b0;
            arb_pulse[BTN_D] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pulse_q <= '0;
            level_q <= '0;
        end else begin
            pulse_q <= arb_pulse;
            level_q <= db;
        end
    end

    assign pulseR    = pulse_q[BTN_R];
    assign pulseL    = pulse_q[BTN_L];
    assign pulseU    = pulse_q[BTN_U];
    assign pulseD    = pulse_q[BTN_D];
    assign btn_level = level_q;

endmodule

// File: tb/tb_btn_step_conditioner.sv
// Directed bench: expected pulse cycles are queued when buttons are driven and
// compared against the DUT on every cycle; a REPEAT_EN=0 copy checks single-shot mode.
module tb_btn_step_conditioner;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btnR = 1'b0, btnL = 1'b0, btnU = 1'b0, btnD = 1'b0;
    logic       pulseR, pulseL, pulseU, pulseD;
    logic [3:0] btn_level;
    logic       nr_pulseR, nr_pulseL, nr_pulseU, nr_pulseD;
    logic [3:0] nr_level;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int nr_cnt = 0;

    typedef struct {
        int         c;
        logic [3:0] v;
    } exp_t;
    exp_t sb[$];

    btn_step_conditioner #(
        .DEBOUNCE_CYCLES (DB), .REPEAT_DELAY (RD), .REPEAT_PERIOD (RP), .REPEAT_EN (1'b1)
    ) dut (
        .clk (clk), .reset (reset),
        .btnR (btnR), .btnL (btnL), .btnU (btnU), .btnD (btnD),
        .pulseR (pulseR), .pulseL (pulseL), .pulseU (pulseU), .pulseD (pulseD),
        .btn_level (btn_level)
    );

    btn_step_conditioner #(
        .DEBOUNCE_CYCLES (DB), .REPEAT_DELAY (RD), .REPEAT_PERIOD (RP), .REPEAT_EN (1'b0)
    ) dut_nr (
        .clk (clk), .reset (reset),
        .btnR (btnR), .btnL (btnL), .btnU (btnU), .btnD (btnD),
        .pulseR (nr_pulseR), .pulseL (nr_pulseL), .pulseU (nr_pulseU), .pulseD (nr_pulseD),
        .btn_level (nr_level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void sb_add(int c, logic [3:0] v);
        exp_t e;
        e.c = c;
        e.v = v;
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].c == c) begin
                sb[i].v = sb[i].v | v;
                return;
            end
            if (sb[i].c > c) begin
                sb.insert(i, e);
                return;
            end
        end
        sb.push_back(e);
    endfunction

    // Press driven at cycle 'start': press pulse DB+3 later, then RD, then every RP,
    // for every pulse visible no later than cycle 'last'.
    task automatic push_press(int b, int start, int last);
        logic [3:0] v;
        int t;
        v = 4'b0001 << b;
        t = start + DB + 3;
        if (t <= last) sb_add(t, v);
        t = t + RD;
        while (t <= last) begin
            sb_add(t, v);
            t = t + RP;
        end
    endtask

    task automatic tick();
        logic [3:0] e, g;
        @(posedge clk);
        #1;
        e = 4'b0000;
        if (sb.size() != 0 && sb[0].c == cyc) begin
            e = sb[0].v;
            void'(sb.pop_front());
        end
        g = {pulseD, pulseU, pulseL, pulseR};
        checks++;
        assert (g === e) else begin
            failures++;
            $error("FAIL pulses cyc=%0d observed=%b expected=%b", cyc, g, e);
        end
        if (nr_pulseU) nr_cnt++;
    endtask

    task automatic run_to(int c);
        while (cyc < c) tick();
    endtask

    task automatic check_lvl(string tag, logic [3:0] exp_v);
        checks++;
        assert (btn_level === exp_v) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, btn_level, exp_v);
        end
    endtask

    initial begin
        run_to(2);
        check_lvl("reset_level", 4'b0000);
        run_to(3);
        reset = 1'b0;

        // Clean press on R, held 12 cycles
        run_to(10);
        btnR = 1'b1;
        push_press(0, 10, 22 + DB + 2);
        run_to(16); check_lvl("t1_level_pre", 4'b0000);
        run_to(17); check_lvl("t1_level_rise", 4'b0001);
        run_to(22); btnR = 1'b0;
        run_to(28); check_lvl("t1_level_hold", 4'b0001);
        run_to(29); check_lvl("t1_level_fall", 4'b0000);

        // Glitch of 3 cycles on R
        run_to(40); btnR = 1'b1;
        run_to(43); btnR = 1'b0;
        run_to(50); check_lvl("t6_glitch_level", 4'b0000);

        // Bounce on L, then a stable hold
        for (int k = 0; k < 10; k++) begin
            run_to(60 + 2 * k);
            btnL = (k % 2 == 0);
        end
        run_to(80); btnL = 1'b1;
        push_press(1, 80, 90 + DB + 2);
        run_to(86); check_lvl("t2_level_pre", 4'b0000);
        run_to(87); check_lvl("t2_level_rise", 4'b0010);
        run_to(90); btnL = 1'b0;

        // Auto-repeat on U held 60 cycles
        run_to(120);
        btnU = 1'b1;
        nr_cnt = 0;
        push_press(2, 120, 180 + DB + 2);
        run_to(180); btnU = 1'b0;
        run_to(186); check_lvl("t3_level_hold", 4'b0100);
        run_to(187); check_lvl("t3_level_fall", 4'b0000);
        run_to(195);
        checks++;
        assert (nr_cnt === 1) else begin
            failures++;
            $error("FAIL norepeat_count observed=%0d expected=1", nr_cnt);
        end

        // R and L together: both suppressed
        run_to(200); btnR = 1'b1; btnL = 1'b1;
        run_to(207); check_lvl("t4_rl_level", 4'b0011);
        run_to(210); btnR = 1'b0; btnL = 1'b0;

        // R and U together: both fire in the same cycle
        run_to(230); btnR = 1'b1; btnU = 1'b1;
        push_press(0, 230, 240 + DB + 2);
        push_press(2, 230, 240 + DB + 2);
        run_to(240); btnR = 1'b0; btnU = 1'b0;

        // All four together: everything suppressed
        run_to(260); btnR = 1'b1; btnL = 1'b1; btnU = 1'b1; btnD = 1'b1;
        run_to(267); check_lvl("t4_all_level", 4'b1111);
        run_to(270); btnR = 1'b0; btnL = 1'b0; btnU = 1'b0; btnD = 1'b0;

        // D held into REPEAT, reset lands on the cycle a repeat pulse is due
        run_to(300); btnD = 1'b1;
        push_press(3, 300, 342);
        run_to(342); reset = 1'b1;
        run_to(343); check_lvl("t5_reset_level", 4'b0000);
        run_to(344); check_lvl("t5_reset_level2", 4'b0000);
        reset = 1'b0;
        push_press(3, 344, 380 + DB + 2);
        run_to(350); check_lvl("t5_level_pre", 4'b0000);
        run_to(351); check_lvl("t5_level_rise", 4'b1000);
        run_to(380); btnD = 1'b0;
        run_to(400);

        checks++;
        assert (sb.size() === 0) else begin
            failures++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
